// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory load/store unit with one-cycle load latency
module load_store_unit #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Address,
  input  logic [31:0] StoreData,
  input  logic        DMWr,
  input  logic        DMRd,
  input  logic [2:0]  DMCtrl,
  output logic [31:0] LoadData,
  output logic        LoadValid,
  output logic        Stall,
  output logic        Misaligned
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  logic [31:0]   mem [DEPTH];
  state_t        state_q, state_d;
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   load_data_q, load_data_d;
  logic          misaligned_q, misaligned_d;

  logic [AW-1:0] word_idx;
  logic          req_word, req_half, req_misalign;
  logic          idle, do_store, do_load;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   ext;
  logic [31:0]   shifted;
  logic          unused_addr;

  // Bits above the memory index are ignored by design.
  assign unused_addr = ^Address[31:AW+2];
  assign word_idx    = Address[AW+1:2];

  // Size decode: funct3[1] selects word (011/110/111 fall into word too), funct3[0] halfword.
  assign req_word     = DMCtrl[1];
  assign req_half     = ~DMCtrl[1] & DMCtrl[0];
  assign req_misalign = req_word ? (Address[1:0] != 2'b00) : (req_half & Address[0]);

  // A store wins over a simultaneous load; misaligned requests do nothing but flag.
  assign idle     = (state_q == IDLE);
  assign do_store = idle & DMWr & ~req_misalign;
  assign do_load  = idle & DMRd & ~DMWr & ~req_misalign;

  // Byte lanes and lane-replicated store data.
  always_comb begin
    be    = 4'b0000;
    wdata = StoreData;
    if (req_word) begin
      be = 4'b1111;
    end else if (req_half) begin
      be    = Address[1] ? 4'b1100 : 4'b0011;
      wdata = {2{StoreData[15:0]}};
    end else begin
      be    = 4'b0001 << Address[1:0];
      wdata = {4{StoreData[7:0]}};
    end
  end

  // Memory array: no reset so contents survive rst_n, but writes are blocked while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Lane select and sign/zero extension of the latched read word.
  always_comb begin
    ext     = rdata_q;
    shifted = rdata_q >> {addr_lo_q, 3'b000};
    if (ctrl_q[1]) begin
      ext = rdata_q;
    end else if (ctrl_q[0]) begin
      ext = {{16{shifted[15] & ~ctrl_q[2]}}, shifted[15:0]};
    end else begin
      ext = {{24{shifted[7] & ~ctrl_q[2]}}, shifted[7:0]};
    end
  end

  // Next-state logic: IDLE launches loads, LOAD_WAIT delivers the result and returns.
  always_comb begin
    state_d      = state_q;
    addr_lo_d    = addr_lo_q;
    ctrl_d       = ctrl_q;
    rdata_d      = rdata_q;
    load_data_d  = load_data_q;
    misaligned_d = misaligned_q;
    case (state_q)
      IDLE: begin
        if ((DMWr | DMRd) & req_misalign) misaligned_d = 1'b1;
        if (do_load) begin
          state_d   = LOAD_WAIT;
          addr_lo_d = Address[1:0];
          ctrl_d    = DMCtrl;
          rdata_d   = mem[word_idx];
        end
      end
      LOAD_WAIT: begin
        load_data_d = ext;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_lo_q    <= 2'b00;
      ctrl_q       <= 3'b000;
      rdata_q      <= 32'h0;
      load_data_q  <= 32'h0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_lo_q    <= addr_lo_d;
      ctrl_q       <= ctrl_d;
      rdata_q      <= rdata_d;
      load_data_q  <= load_data_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign LoadValid  = (state_q == LOAD_WAIT);
  assign LoadData   = LoadValid ? ext : load_data_q;
  assign Stall      = rst_n & do_load;
  assign Misaligned = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard testbench for load_store_unit
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] Address;
  logic [31:0] StoreData;
  logic        DMWr;
  logic        DMRd;
  logic [2:0]  DMCtrl;
  logic [31:0] LoadData;
  logic        LoadValid;
  logic        Stall;
  logic        Misaligned;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010;
  localparam logic [2:0] F_BU = 3'b100, F_HU = 3'b101;

  load_store_unit #(.DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .Address(Address), .StoreData(StoreData),
    .DMWr(DMWr), .DMRd(DMRd), .DMCtrl(DMCtrl), .LoadData(LoadData),
    .LoadValid(LoadValid), .Stall(Stall), .Misaligned(Misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every LoadValid pulse must match the oldest expected load result.
  initial begin
    forever begin
      @(negedge clk);
      if (LoadValid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_loadvalid", 32'd1, 32'd0);
        end else begin
          check("load_data", LoadData, exp_q.pop_front());
        end
      end
    end
  end

  task automatic clear_inputs();
    DMWr = 1'b0; DMRd = 1'b0; Address = 32'h0; StoreData = 32'h0; DMCtrl = F_W;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f);
    Address = addr; StoreData = data; DMCtrl = f; DMWr = 1'b1; DMRd = 1'b0;
    @(negedge clk);
    check("store_stall", {31'd0, Stall}, 32'd0);
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] f, input logic [31:0] exp);
    Address = addr; DMCtrl = f; DMRd = 1'b1; DMWr = 1'b0;
    exp_q.push_back(exp);
    @(negedge clk);
    check("load_stall", {31'd0, Stall}, 32'd1);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    check("wait_stall", {31'd0, Stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    DMRd = 1'b1; Address = 32'h10;
    #12;
    check("rst_loaddata", LoadData, 32'h0);
    check("rst_loadvalid", {31'd0, LoadValid}, 32'd0);
    check("rst_stall", {31'd0, Stall}, 32'd0);
    check("rst_misaligned", {31'd0, Misaligned}, 32'd0);
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    store(32'h10, 32'h8000_00F1, F_W);
    load(32'h10, F_W, 32'h8000_00F1);
    load(32'h10, F_B, 32'hFFFF_FFF1);
    load(32'h10, F_BU, 32'h0000_00F1);
    load(32'h12, F_H, 32'hFFFF_8000);
    load(32'h12, F_HU, 32'h0000_8000);
    load(32'h13, F_B, 32'hFFFF_FF80);
    load(32'h10, F_H, 32'h0000_00F1);
    load(32'h1010, F_W, 32'h8000_00F1);

    store(32'h11, 32'h1234_56AA, F_B);
    load(32'h10, F_W, 32'h8000_AAF1);
    store(32'h14, 32'h1122_3344, F_W);
    store(32'h16, 32'hCAFE_BEEF, F_H);
    load(32'h14, F_W, 32'hBEEF_3344);
    store(32'h18, 32'hA5A5_A5A5, 3'b011);
    load(32'h18, 3'b111, 32'hA5A5_A5A5);

    // Store and load together: store only, no stall, no load result.
    Address = 32'h20; StoreData = 32'h1234_5678; DMCtrl = F_W; DMWr = 1'b1; DMRd = 1'b1;
    @(negedge clk);
    check("dual_stall", {31'd0, Stall}, 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    check("dual_no_valid", {31'd0, LoadValid}, 32'd0);
    @(posedge clk); #1;
    load(32'h20, F_W, 32'h1234_5678);

    check("misaligned_before", {31'd0, Misaligned}, 32'd0);
    Address = 32'h13; StoreData = 32'hFFFF_FFFF; DMCtrl = F_W; DMWr = 1'b1;
    @(negedge clk);
    check("mis_store_stall", {31'd0, Stall}, 32'd0);
    check("mis_not_yet", {31'd0, Misaligned}, 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    check("mis_set", {31'd0, Misaligned}, 32'd1);
    load(32'h10, F_W, 32'h8000_AAF1);
    Address = 32'h11; DMCtrl = F_H; DMRd = 1'b1;
    @(negedge clk);
    check("mis_load_stall", {31'd0, Stall}, 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    load(32'h10, F_W, 32'h8000_AAF1);
    check("mis_sticky", {31'd0, Misaligned}, 32'd1);

    // Reset in the middle of LOAD_WAIT aborts the load; memory survives.
    store(32'h40, 32'h1111_1111, F_W);
    Address = 32'h10; DMCtrl = F_W; DMRd = 1'b1;
    @(posedge clk); #1;
    clear_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_loadvalid", {31'd0, LoadValid}, 32'd0);
    check("abort_loaddata", LoadData, 32'h0);
    check("abort_stall", {31'd0, Stall}, 32'd0);
    check("abort_misaligned", {31'd0, Misaligned}, 32'd0);
    Address = 32'h40; StoreData = 32'hDEAD_DEAD; DMCtrl = F_W; DMWr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_no_valid", {31'd0, LoadValid}, 32'd0);
    @(posedge clk); #1;
    load(32'h10, F_W, 32'h8000_AAF1);
    load(32'h40, F_W, 32'h1111_1111);
    @(negedge clk);
    check("hold_loaddata", LoadData, 32'h1111_1111);
    check("hold_loadvalid", {31'd0, LoadValid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
